// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, streams one aligned block
// from pipelined memory, pulsing data writes and a final tag write.
module cache_fill_fsm #(
  parameter int WORDS_LOG2 = 3,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_read_req,
  output logic [ADDR_W-1:0]     memory_address,
  output logic [WORDS_LOG2-1:0] fill_word,
  output logic                  write_data_array,
  output logic                  write_tag_array
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [ADDR_W-1:0] BLK_MASK =
    ADDR_W'((1 << (WORDS_LOG2 + 1)) - 1);
  localparam logic [WORDS_LOG2:0]   ISS_ONE = 1;
  localparam logic [WORDS_LOG2-1:0] RCV_ONE = 1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [WORDS_LOG2:0]   issue_q, issue_d;
  logic [WORDS_LOG2-1:0] recv_q, recv_d;

  logic              in_fill;
  logic              last_word;
  logic [ADDR_W-1:0] word_off;

  assign in_fill   = (state_q == S_FILL);
  assign last_word = (recv_q == {WORDS_LOG2{1'b1}});

  // issue_q's top bit marks "all words requested"
  assign word_off = {{(ADDR_W-WORDS_LOG2-1){1'b0}},
                     issue_q[WORDS_LOG2-1:0], 1'b0};

  assign fsm_busy         = in_fill | miss_detected;
  assign mem_read_req     = in_fill & ~issue_q[WORDS_LOG2];
  assign memory_address   = mem_read_req ? base_q + word_off
                                         : base_q;
  assign write_data_array = in_fill & memory_data_valid;
  assign write_tag_array  = write_data_array & last_word;
  assign fill_word        = recv_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          state_d = S_FILL;
          base_d  = miss_address & ~BLK_MASK;
          issue_d = '0;
          recv_d  = '0;
        end
      end
      default: begin
        if (mem_read_req) begin
          issue_d = issue_q + ISS_ONE;
        end
        if (memory_data_valid) begin
          recv_d = recv_q + RCV_ONE;
          if (last_word) begin
            state_d = S_IDLE;
            issue_d = '0;
            recv_d  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed misses against a latency-configurable
// memory, with a fill-schedule model checked every cycle.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_req;
  logic [15:0] memory_address;
  logic [2:0]  fill_word;
  logic        write_data_array;
  logic        write_tag_array;

  cache_fill_fsm #(.WORDS_LOG2(3), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy),
    .mem_read_req(mem_read_req),
    .memory_address(memory_address),
    .fill_word(fill_word),
    .write_data_array(write_data_array),
    .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // fill model: a fill starts in the miss cycle, requests words in the
  // 8 cycles after it, and ends with the 8th returned word
  int          cyc = 0;
  bit          started = 0;
  bit          m_fill = 0;
  logic [15:0] m_base = '0;
  int          m_start = 0;
  int          m_rcv = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_fill = 0;
      m_base = '0;
      m_rcv  = 0;
    end else if (!m_fill) begin
      if (miss_detected) begin
        m_fill  = 1;
        m_base  = miss_address & 16'hFFF0;
        m_start = cyc;
        m_rcv   = 0;
      end
    end else if (memory_data_valid) begin
      if (m_rcv == 7) m_fill = 0;
      m_rcv++;
    end
    cyc++;
    started = 1;
  end

  // memory: each observed request returns data lat cycles later
  int          lat = 4;
  int          mq[$];
  logic [15:0] req_log[$];
  int          fw_log[$];
  int          busy_cnt, wr_cnt, tag_cnt;

  always @(negedge clk) begin
    int          off;
    bit          e_req, e_wr;
    logic [15:0] e_addr;
    if (started) begin
      off    = cyc - m_start;
      e_req  = m_fill && off >= 1 && off <= 8;
      e_addr = e_req ? m_base + 16'(2 * (off - 1)) : m_base;
      e_wr   = m_fill && memory_data_valid;
      chk("busy", int'(fsm_busy), int'(m_fill || miss_detected));
      chk("req", int'(mem_read_req), int'(e_req));
      chk("addr", int'(memory_address), int'(e_addr));
      chk("wr", int'(write_data_array), int'(e_wr));
      chk("tag", int'(write_tag_array), int'(e_wr && m_rcv == 7));
      if (e_wr) chk("fill_word", int'(fill_word), m_rcv);
    end
    if (mem_read_req) begin
      mq.push_back(cyc + lat);
      req_log.push_back(memory_address);
    end
    if (fsm_busy) busy_cnt++;
    if (write_data_array) begin
      wr_cnt++;
      fw_log.push_back(int'(fill_word));
    end
    if (write_tag_array) tag_cnt++;
  end

  bit force_v = 0;

  task automatic tick();
    bit v;
    @(posedge clk);
    #1;
    while (mq.size() > 0 && mq[0] < cyc) void'(mq.pop_front());
    v = 0;
    if (mq.size() > 0 && mq[0] == cyc) begin
      v = 1;
      void'(mq.pop_front());
    end
    memory_data_valid = v | force_v;
  endtask

  task automatic clear_logs();
    req_log.delete();
    fw_log.delete();
    busy_cnt = 0;
    wr_cnt   = 0;
    tag_cnt  = 0;
  endtask

  task automatic chk_words(string name);
    chk({name, "_nwr"}, fw_log.size(), 8);
    for (int k = 0; k < fw_log.size() && k < 8; k++)
      chk({name, "_fw_order"}, fw_log[k], k);
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(fsm_busy), 0);
    chk("rst_req", int'(mem_read_req), 0);
    chk("rst_addr", int'(memory_address), 0);
    chk("rst_wr", int'(write_data_array), 0);
    rst = 1'b0;
    tick();

    // miss at 0x1234, latency 4
    lat = 4;
    clear_logs();
    miss_detected = 1'b1;
    miss_address = 16'h1234;
    #1;
    chk("t1_busy_same_cycle", int'(fsm_busy), 1);
    tick();
    miss_detected = 1'b0;
    repeat (12) tick();
    chk("t2_busy_after", int'(fsm_busy), 0);
    repeat (3) tick();
    chk("t1_nreq", req_log.size(), 8);
    chk("t1_first_addr", int'(req_log[0]), 16'h1230);
    chk("t1_addr3", int'(req_log[3]), 16'h1236);
    chk("t1_last_addr", int'(req_log[7]), 16'h123E);
    chk("t2_busy_cycles", busy_cnt, 13);
    chk("t2_tags", tag_cnt, 1);
    chk_words("t2");

    // second miss held throughout a fill, latency 2
    lat = 2;
    clear_logs();
    miss_detected = 1'b1;
    miss_address = 16'h1234;
    tick();
    miss_address = 16'h5000;
    repeat (11) tick();
    miss_detected = 1'b0;
    repeat (16) tick();
    chk("t3_nreq", req_log.size(), 16);
    chk("t3_a_last", int'(req_log[7]), 16'h123E);
    chk("t3_b_first", int'(req_log[8]), 16'h5000);
    chk("t3_b_last", int'(req_log[15]), 16'h500E);
    chk("t3_busy_cycles", busy_cnt, 22);
    chk("t3_tags", tag_cnt, 2);

    // reset after three data writes
    lat = 4;
    clear_logs();
    miss_detected = 1'b1;
    miss_address = 16'h2000;
    tick();
    miss_detected = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy", int'(fsm_busy), 0);
    chk("t4_req", int'(mem_read_req), 0);
    chk("t4_addr", int'(memory_address), 0);
    repeat (10) tick();
    chk("t4_writes", wr_cnt, 3);
    chk("t4_tags", tag_cnt, 0);

    // block at the top of the address space, latency 1
    lat = 1;
    clear_logs();
    miss_detected = 1'b1;
    miss_address = 16'hFFF8;
    tick();
    miss_detected = 1'b0;
    repeat (12) tick();
    chk("t5_nreq", req_log.size(), 8);
    chk("t5_first_addr", int'(req_log[0]), 16'hFFF0);
    chk("t5_last_addr", int'(req_log[7]), 16'hFFFE);
    chk("t5_busy_cycles", busy_cnt, 10);
    chk("t5_tags", tag_cnt, 1);
    chk_words("t5");

    // valids with no miss pending
    clear_logs();
    force_v = 1;
    repeat (4) tick();
    force_v = 0;
    tick();
    chk("t6_writes", wr_cnt, 0);
    chk("t6_tags", tag_cnt, 0);
    chk("t6_busy", busy_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
